// File: rtl/pux_si_master.sv
// -----------------------------------------------------------------------------
// pux_si_master
//   Initiator-side partner of pux_si. Accepts one host command at a time,
//   issues it as a single opcode beat on the AXIS opcode channel, sinks the
//   matching status beat (or times out) and returns {opcode, status, timeout}
//   to the host. Exactly one opcode is ever outstanding.
//
// Ports
//   axis_clk, axis_rstn               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_opcode    host command channel (ready only in IDLE)
//   axis_opcode_data/valid/ready      opcode beat to pux_si
//   axis_status_data/valid/ready      status beat from pux_si (ready only in WAIT_STS)
//   rsp_valid/ready/opcode/status/timeout
//                                     response to host; status is 0 on timeout
//   busy                              high whenever the FSM is not IDLE
//
// Every output is taken straight from a register.
// -----------------------------------------------------------------------------
module pux_si_master #(
  parameter int OPCW       = 8,
  parameter int STATUSW    = 2,
  parameter int TMO_CYCLES = 200   // legal range 1..65535
) (
  input  logic               axis_clk,
  input  logic               axis_rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OPCW-1:0]    cmd_opcode,
  output logic [OPCW-1:0]    axis_opcode_data,
  output logic               axis_opcode_valid,
  input  logic               axis_opcode_ready,
  input  logic [STATUSW-1:0] axis_status_data,
  input  logic               axis_status_valid,
  output logic               axis_status_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [OPCW-1:0]    rsp_opcode,
  output logic [STATUSW-1:0] rsp_status,
  output logic               rsp_timeout,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Timer value on which WAIT_STS gives up if no status has arrived.
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  state_e             state_q;
  logic [OPCW-1:0]    opc_q;        // latched command; feeds both opcode beat and response
  logic               opc_valid_q;
  logic               sts_ready_q;
  logic               rsp_valid_q;
  logic [STATUSW-1:0] rsp_sts_q;
  logic               rsp_tmo_q;
  logic               cmd_ready_q;
  logic               busy_q;
  logic [15:0]        timer_q;
  logic [15:0]        timer_d;

  // Saturating increment: the timer sticks at all-ones instead of wrapping.
  assign timer_d = (timer_q == 16'hFFFF) ? timer_q : (timer_q + 16'd1);

  // Command FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state_q     <= S_IDLE;
      opc_q       <= '0;
      opc_valid_q <= 1'b0;
      sts_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sts_q   <= '0;
      rsp_tmo_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      timer_q     <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // cmd_ready comes up on the first cycle after reset release.
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            opc_q       <= cmd_opcode;
            cmd_ready_q <= 1'b0;
            opc_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          if (axis_opcode_ready) begin
            opc_valid_q <= 1'b0;
            sts_ready_q <= 1'b1;
            timer_q     <= 16'd0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer_q <= timer_d;
          // A status on the final timer cycle still wins over the timeout.
          if (axis_status_valid && sts_ready_q) begin
            rsp_sts_q   <= axis_status_data;
            rsp_tmo_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            sts_ready_q <= 1'b0;
            state_q     <= S_RESP;
          end else if (timer_q == TMO_LAST) begin
            rsp_sts_q   <= '0;
            rsp_tmo_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            sts_ready_q <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a quiet IDLE.
          state_q     <= S_IDLE;
          opc_valid_q <= 1'b0;
          sts_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign axis_opcode_data  = opc_q;
  assign axis_opcode_valid = opc_valid_q;
  assign axis_status_ready = sts_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_opcode        = opc_q;
  assign rsp_status        = rsp_sts_q;
  assign rsp_timeout       = rsp_tmo_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_pux_si_master.sv
// Testbench for pux_si_master: scenario tasks with inline comparisons against
// a transaction-level reference model (response tuple and wait time derived
// from the status delay and the timeout limit).
module tb_pux_si_master;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_opcode;
  logic [7:0] axis_opcode_data;
  logic       axis_opcode_valid;
  logic       axis_opcode_ready;
  logic [1:0] axis_status_data;
  logic       axis_status_valid;
  logic       axis_status_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_opcode;
  logic [1:0] rsp_status;
  logic       rsp_timeout;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pux_si_master #(.OPCW(8), .STATUSW(2), .TMO_CYCLES(TMO)) dut (
    .axis_clk          (clk),
    .axis_rstn         (rstn),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_opcode        (cmd_opcode),
    .axis_opcode_data  (axis_opcode_data),
    .axis_opcode_valid (axis_opcode_valid),
    .axis_opcode_ready (axis_opcode_ready),
    .axis_status_data  (axis_status_data),
    .axis_status_valid (axis_status_valid),
    .axis_status_ready (axis_status_ready),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_opcode        (rsp_opcode),
    .rsp_status        (rsp_status),
    .rsp_timeout       (rsp_timeout),
    .busy              (busy)
  );

  // Reference model: response tuple {opcode, status, timeout}.
  function automatic logic [10:0] model_rsp(input logic [7:0] opc, input int sts_dly, input logic [1:0] sts);
    bit tmo;
    tmo = (sts_dly < 0) || (sts_dly >= TMO);
    return tmo ? {opc, 2'b00, 1'b1} : {opc, sts, 1'b0};
  endfunction

  // Reference model: cycles from entering WAIT_STS until rsp_valid is seen.
  function automatic int model_wait(input int sts_dly);
    return ((sts_dly < 0) || (sts_dly >= TMO)) ? TMO : sts_dly + 1;
  endfunction

  // Drives one full command; reports what was observed and a protocol flag.
  task automatic do_cmd(input logic [7:0] opc, input int op_dly, input int sts_dly,
                        input logic [1:0] sts, input int rsp_dly,
                        output logic [7:0] beat, output logic [10:0] rsp,
                        output int wcyc, output bit ok);
    int n;
    ok = 1'b1; wcyc = -1; beat = 8'hxx; rsp = 11'hxxx; n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (cmd_ready !== 1'b1) begin ok = 1'b0; return; end
    cmd_valid = 1'b1; cmd_opcode = opc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_opcode = 8'($urandom);
    if (axis_opcode_valid !== 1'b1 || axis_opcode_data !== opc || busy !== 1'b1 || cmd_ready !== 1'b0) ok = 1'b0;
    for (int i = 0; i < op_dly; i++) begin
      @(negedge clk);
      if (axis_opcode_valid !== 1'b1 || axis_opcode_data !== opc || axis_status_ready !== 1'b0 || cmd_ready !== 1'b0) ok = 1'b0;
    end
    axis_opcode_ready = 1'b1; beat = axis_opcode_data;
    @(negedge clk);
    axis_opcode_ready = 1'b0;
    if (axis_opcode_valid !== 1'b0 || axis_status_ready !== 1'b1) ok = 1'b0;
    for (int k = 0; k < TMO + 20; k++) begin
      axis_status_valid = (k == sts_dly);
      axis_status_data  = (k == sts_dly) ? sts : 2'($urandom);
      @(negedge clk);
      if (rsp_valid === 1'b1) begin wcyc = k + 1; break; end
      if (axis_status_ready !== 1'b1) ok = 1'b0;
    end
    axis_status_valid = 1'b0;
    if (wcyc < 0) return;
    rsp = {rsp_opcode, rsp_status, rsp_timeout};
    if (axis_status_ready !== 1'b0) ok = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_opcode, rsp_status, rsp_timeout} !== rsp || cmd_ready !== 1'b0
          || axis_status_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    outs = {cmd_ready, axis_opcode_data, axis_opcode_valid, axis_status_ready, rsp_valid,
            rsp_opcode, rsp_status, rsp_timeout, busy};
    n_checks++;
    if (outs !== 24'd0) $display("FAIL reset_outputs: got %h expected %h", outs, 24'd0);
    else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy} !== 2'b10) $display("FAIL reset_release: {cmd_ready,busy} got %b expected 10", {cmd_ready, busy});
    else n_pass++;
  endtask

  // Runs one command and compares beat, response, wait time and protocol flag.
  task automatic test_one(input string name, input logic [7:0] opc, input int op_dly,
                          input int sts_dly, input logic [1:0] sts, input int rsp_dly);
    logic [7:0] beat; logic [10:0] rsp, exp_rsp; int wcyc, exp_wait; bit ok;
    exp_rsp  = model_rsp(opc, sts_dly, sts);
    exp_wait = model_wait(sts_dly);
    do_cmd(opc, op_dly, sts_dly, sts, rsp_dly, beat, rsp, wcyc, ok);
    n_checks++;
    if (beat !== opc) $display("FAIL %s_beat: got %h expected %h", name, beat, opc);
    else n_pass++;
    n_checks++;
    if (rsp !== exp_rsp) $display("FAIL %s_rsp: {opc,sts,tmo} got %h expected %h", name, rsp, exp_rsp);
    else n_pass++;
    n_checks++;
    if (wcyc !== exp_wait) $display("FAIL %s_wait: got %0d expected %0d", name, wcyc, exp_wait);
    else n_pass++;
    n_checks++;
    if (ok !== 1'b1) $display("FAIL %s_protocol: got %0d expected 1", name, ok);
    else n_pass++;
  endtask

  task automatic test_basic();
    test_one("basic", 8'h17, 0, 3, 2'd1, 0);
  endtask

  task automatic test_backpressure();
    test_one("backpressure", 8'h23, 10, 2, 2'd2, 5);
  endtask

  task automatic test_timeout();
    test_one("timeout", 8'h5A, 0, -1, 2'd3, 0);
    test_one("status_last_cycle", 8'h66, 0, TMO - 1, 2'd3, 1);
  endtask

  task automatic test_sequence();
    logic [7:0] opcs [6] = '{8'h23, 8'h02, 8'h31, 8'h17, 8'h12, 8'h01};
    logic [1:0] stss [6] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    logic [10:0] expq [$];
    logic [10:0] exp_rsp, rsp; logic [7:0] beat; int wcyc, sd; bit ok;
    for (int i = 0; i < 6; i++) expq.push_back({opcs[i], stss[i], 1'b0});
    for (int i = 0; i < 6; i++) begin
      sd = $urandom_range(0, 5);
      do_cmd(opcs[i], $urandom_range(0, 2), sd, stss[i], $urandom_range(0, 2), beat, rsp, wcyc, ok);
      exp_rsp = expq.pop_front();
      n_checks++;
      if (rsp !== exp_rsp) $display("FAIL seq%0d_rsp: got %h expected %h", i, rsp, exp_rsp);
      else n_pass++;
      n_checks++;
      if ({ok, wcyc} !== {1'b1, model_wait(sd)}) $display("FAIL seq%0d_timing: ok %0d wait %0d expected ok 1 wait %0d", i, ok, wcyc, model_wait(sd));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int sd;
    for (int i = 0; i < 15; i++) begin
      if ($urandom_range(0, 9) < 2) sd = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(TMO - 3, TMO + 5);
      else sd = $urandom_range(0, 8);
      test_one($sformatf("rand%0d", i), 8'($urandom), $urandom_range(0, 4), sd, 2'($urandom), $urandom_range(0, 4));
    end
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 8'h44;
    @(negedge clk);
    cmd_valid = 1'b0; axis_opcode_ready = 1'b1;
    @(negedge clk);
    axis_opcode_ready = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, axis_status_ready, rsp_valid} !== 3'b000) $display("FAIL midreset_busy: {busy,sts_ready,rsp_valid} got %b expected 000", {busy, axis_status_ready, rsp_valid});
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    saw_rsp = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) saw_rsp = 1'b1;
    end
    n_checks++;
    if (saw_rsp !== 1'b0) $display("FAIL midreset_no_rsp: got %0d expected 0", saw_rsp);
    else n_pass++;
    test_one("after_reset", 8'h9C, 1, 4, 2'd2, 1);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_opcode = 8'h00; axis_opcode_ready = 1'b0;
    axis_status_data = 2'd0; axis_status_valid = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_sequence();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
